alu_muldiv_seq: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit beside the single-cycle alu.

---
 rtl/alu_muldiv_seq.sv | 157 +++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Radix-2 sequential multiply/divide unit with MIPS-style hi/lo results.
// Define ALU_MULDIV_DIV_EN to include the restoring divider; without it DIV/DIVU report dz=1.
module alu_muldiv_seq #(
  parameter int OPR_L = 32,
  parameter int CNT_L = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [OPR_L-1:0] A,
  input  logic [OPR_L-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [OPR_L-1:0] hi,
  output logic [OPR_L-1:0] lo,
  output logic             dz
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  localparam logic [CNT_L-1:0] LAST_ITER = CNT_L'(OPR_L - 1);

  state_t             state_q;
  logic [CNT_L-1:0]   cnt_q;
  logic [2*OPR_L-1:0] acc_q;     // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [OPR_L-1:0]   opnd_q;    // MUL: multiplicand; DIV: divisor
  logic               neg_lo_q;  // negate product (MUL) or quotient (DIV)
  logic               zpath_q;   // divide-by-zero / unsupported-op path
  logic               busy_q, done_q, dz_q;
  logic [OPR_L-1:0]   hi_q, lo_q;
  logic [2*OPR_L-1:0] mul_next;
  logic [OPR_L:0]     mul_sum;

  function automatic logic [OPR_L-1:0] mag(input logic [OPR_L-1:0] x, input logic sgn);
    return (sgn && x[OPR_L-1]) ? -x : x;
  endfunction

  // Shift-add step: conditionally add the multiplicand into the upper half, then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*OPR_L-1:OPR_L]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[OPR_L-1:1]};
  end

`ifdef ALU_MULDIV_DIV_EN
  logic               div_q;
  logic               neg_hi_q;  // remainder takes the dividend's sign
  logic [OPR_L:0]     rem_sh;
  logic               rem_ge;
  logic [OPR_L-1:0]   rem_new;
  logic [2*OPR_L-1:0] div_next;

  // Restoring step: the remainder stays below the divisor, so the subtraction fits OPR_L bits.
  always_comb begin
    rem_sh   = {acc_q[2*OPR_L-1:OPR_L], acc_q[OPR_L-1]};
    rem_ge   = rem_sh >= {1'b0, opnd_q};
    rem_new  = rem_ge ? (rem_sh[OPR_L-1:0] - opnd_q) : rem_sh[OPR_L-1:0];
    div_next = {rem_new, acc_q[OPR_L-2:0], rem_ge};
  end
`endif

  // NOTE: all state below is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      zpath_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef ALU_MULDIV_DIV_EN
      div_q    <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            neg_lo_q <= op[0] & (A[OPR_L-1] ^ B[OPR_L-1]);
            zpath_q  <= 1'b0;
            acc_q    <= {{OPR_L{1'b0}}, mag(B, op[0])};
            opnd_q   <= mag(A, op[0]);
            state_q  <= S_CALC;
`ifdef ALU_MULDIV_DIV_EN
            div_q    <= op[1];
            neg_hi_q <= op[0] & A[OPR_L-1];
            if (op[1]) begin
              acc_q  <= {{OPR_L{1'b0}}, mag(A, op[0])};
              opnd_q <= mag(B, op[0]);
              if (B == '0) begin
                acc_q   <= {{OPR_L{1'b0}}, A};
                zpath_q <= 1'b1;
                state_q <= S_FIX;
              end
            end
`else
            if (op[1]) begin
              zpath_q <= 1'b1;
              state_q <= S_FIX;
            end
`endif
          end
        end
        S_CALC: begin
`ifdef ALU_MULDIV_DIV_EN
          acc_q <= div_q ? div_next : mul_next;
`else
          acc_q <= mul_next;
`endif
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_q <= S_FIX;
        end
        S_FIX: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          dz_q    <= zpath_q;
          state_q <= S_IDLE;
          if (zpath_q) begin
`ifdef ALU_MULDIV_DIV_EN
            hi_q <= acc_q[OPR_L-1:0];
            lo_q <= '1;
`else
            hi_q <= '0;
            lo_q <= '0;
`endif
          end
`ifdef ALU_MULDIV_DIV_EN
          else if (div_q) begin
            lo_q <= neg_lo_q ? -acc_q[OPR_L-1:0] : acc_q[OPR_L-1:0];
            hi_q <= neg_hi_q ? -acc_q[2*OPR_L-1:OPR_L] : acc_q[2*OPR_L-1:OPR_L];
          end
`endif
          else begin
            {hi_q, lo_q} <= neg_lo_q ? -acc_q : acc_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized self-checking bench for alu_muldiv_seq (OPR_L=32) against an arithmetic reference model.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = '0, B = '0;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  alu_muldiv_seq #(.OPR_L(32), .CNT_L(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: {dz, hi, lo} from plain arithmetic on the operands.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    int qs, rs;
    if (!o[1]) begin
      if (o[0]) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
      end else begin
        p = {32'h0, a} * {32'h0, b};
      end
      return {1'b0, p};
    end
`ifdef ALU_MULDIV_DIV_EN
    if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
    if (!o[0]) return {1'b0, a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
    qs = $signed(a) / $signed(b);
    rs = $signed(a) % $signed(b);
    return {1'b0, 32'(rs), 32'(qs)};
`else
    return {1'b1, 64'h0};
`endif
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] b);
`ifdef ALU_MULDIV_DIV_EN
    if (o[1] && b == 32'h0) return 1;
`else
    if (o[1]) return 1;
`endif
    return 33;
  endfunction

  // Wait (bounded) for done; returns edges counted since the accept edge.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 200);
  endtask

  task automatic check_result(input string tag, input logic [1:0] o, input logic [31:0] a,
                              input logic [31:0] b, input int n);
    logic [64:0] e;
    e = model(o, a, b);
    check({tag, " latency"}, 64'(n), 64'(model_lat(o, b)));
    check({tag, " hi/lo"}, {hi, lo}, e[63:0]);
    check({tag, " dz"}, 64'(dz), 64'(e[64]));
    check({tag, " busy at done"}, 64'(busy), 64'h0);
  endtask

  // One operation: present at negedge, accepted at next posedge, then inputs scrambled.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); A = $urandom; B = $urandom;
    check({tag, " busy"}, 64'(busy), 64'h1);
    wait_done(n);
    check_result(tag, o, a, b, n);
  endtask

  initial begin
    int n, dones;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [31:0] corners [4];
    corners[0] = 32'h8000_0000; corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h0000_0001; corners[3] = 32'h7FFF_FFFF;

    #12;
    check("reset busy", 64'(busy), 64'h0);
    check("reset done", 64'(done), 64'h0);
    check("reset hi/lo", {hi, lo}, 64'h0);
    check("reset dz", 64'(dz), 64'h0);
    @(negedge clk); rst = 1'b0;

    run_op("multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult -3*7", 2'b01, 32'hFFFF_FFFD, 32'h0000_0007);
    run_op("div -7/2",  2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op("divu 7/2",  2'b10, 32'h0000_0007, 32'h0000_0002);
    run_op("divu /0",   2'b10, 32'h0000_1234, 32'h0000_0000);
    run_op("multu 2*3", 2'b00, 32'h0000_0002, 32'h0000_0003);
    run_op("div 7/2",   2'b11, 32'h0000_0007, 32'h0000_0002);
    run_op("div min/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mult min*min", 2'b01, 32'h8000_0000, 32'h8000_0000);
    run_op("div 7/-2",  2'b11, 32'h0000_0007, 32'hFFFF_FFFE);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = (i % 5 == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = corners[$urandom_range(0, 3)];
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb);
    end

    // Start held high: second request only taken in the done cycle of the first.
    @(negedge clk);
    start = 1'b1; op = 2'b00; A = 32'd5; B = 32'd6;
    @(posedge clk); #1;
    A = 32'd7; B = 32'd8;
    wait_done(n);
    check_result("held 5*6", 2'b00, 32'd5, 32'd6, n);
    @(posedge clk); #1;
    start = 1'b0;
    check("held done pulse", 64'(done), 64'h0);
    check("held second busy", 64'(busy), 64'h1);
    wait_done(n);
    check_result("held 7*8", 2'b00, 32'd7, 32'd8, n);

    // Reset in the middle of an operation discards it.
    @(negedge clk);
    start = 1'b1; op = 2'b00; A = 32'd9; B = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst busy", 64'(busy), 64'h0);
    check("midrst done", 64'(done), 64'h0);
    check("midrst hi/lo", {hi, lo}, 64'h0);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("midrst no done", 64'(dones), 64'h0);
    check("midrst idle busy", 64'(busy), 64'h0);

    run_op("post rst mult", 2'b01, 32'hFFFF_FFFF, 32'h0000_0005);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
